// File: rtl/cim_pkg.sv
// Shared types and helpers for the compute-in-memory tile: FSM state encoding,
// accumulator sizing and commit-time saturation.
package cim_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   // Wide enough for xbar_size additions of the largest input without wrap.
   function automatic int acc_width(input int xbar_size, input int datatype_size);
      return datatype_size + $clog2(xbar_size) + 1;
   endfunction

   // Unsigned clamp to the largest value representable in out_w bits (out_w < 32).
   function automatic logic [31:0] sat_u(input logic [31:0] v, input int unsigned out_w);
      logic [31:0] max_v;
      max_v = (32'd1 << out_w) - 32'd1;
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/cim_tile_if.sv
// Layer-controller <-> tile bus: input-buffer writes, weight writes, start/busy/done
// handshake and output-buffer reads.
interface cim_tile_if #(
   parameter int xbar_size            = 256,
   parameter int datatype_size        = 2,
   parameter int output_datatype_size = 2
);
   localparam int AW = $clog2(xbar_size);

   logic                            i_we;
   logic [AW-1:0]                   i_wr_addr;
   logic [datatype_size-1:0]        i_wr_data;
   logic                            i_start;
   logic                            o_busy;
   logic                            o_done;
   logic                            i_w_we;
   logic [AW-1:0]                   i_w_row;
   logic [xbar_size-1:0]            i_w_data;
   logic [AW-1:0]                   i_rd_addr;
   logic [output_datatype_size-1:0] o_rd_data;

   modport master (
      output i_we, i_wr_addr, i_wr_data, i_start, i_w_we, i_w_row, i_w_data, i_rd_addr,
      input  o_busy, o_done, o_rd_data
   );

   modport slave (
      input  i_we, i_wr_addr, i_wr_data, i_start, i_w_we, i_w_row, i_w_data, i_rd_addr,
      output o_busy, o_done, o_rd_data
   );

endinterface

// File: rtl/cim_obuf.sv
// Output buffer: one register per column, all columns written together on commit,
// single registered read port that returns pre-write contents on a write edge.
module cim_obuf #(
   parameter int depth = 256,
   parameter int width = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                we,
   input  logic [depth-1:0][width-1:0]         wdata,
   input  logic [$clog2(depth)-1:0]            raddr,
   output logic [width-1:0]                    rdata
);

   logic [depth-1:0][width-1:0] mem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '0;
         rdata <= '0;
      end else begin
         if (we) mem_q <= wdata;
         rdata <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/cim_tile.sv
// Binary-weight crossbar tile: streams one input row per cycle into per-column
// accumulators, then saturates and commits all columns to the output buffer at once.
module cim_tile
   import cim_pkg::*;
#(
   parameter int xbar_size            = 256,
   parameter int datatype_size        = 2,
   parameter int output_datatype_size = 2
) (
   input  logic      clk,
   input  logic      rst,
   cim_tile_if.slave bus
);

   localparam int AW    = $clog2(xbar_size);
   localparam int ACC_W = acc_width(xbar_size, datatype_size);
   localparam logic [AW-1:0] LAST_ROW = AW'(xbar_size - 1);

   state_t state_q, state_d;
   logic   acc_clr, acc_en, commit;
   logic   done_q;
   logic   idle;

   logic [AW-1:0]                                 row_q;
   logic [xbar_size-1:0][datatype_size-1:0]       ibuf_q;
   logic [xbar_size-1:0][xbar_size-1:0]           w_q;
   logic [xbar_size-1:0][ACC_W-1:0]               acc_q;
   logic [xbar_size-1:0][output_datatype_size-1:0] sat_d;
   logic [datatype_size-1:0]                      row_in;
   logic [xbar_size-1:0]                          row_w;

   assign idle   = (state_q == IDLE);
   assign row_in = ibuf_q[row_q];
   assign row_w  = w_q[row_q];

   assign bus.o_busy = !idle;
   assign bus.o_done = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               acc_clr = 1'b1;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            acc_en = 1'b1;
            if (row_q == LAST_ROW) state_d = COMMIT;
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= commit;
         if (acc_clr)     row_q <= '0;
         else if (acc_en) row_q <= row_q + 1'b1;
      end
   end

   // Buffers are frozen outside IDLE; a write and a start in the same idle cycle
   // both land, and the write is visible to the first compute row.
   always_ff @(posedge clk) begin
      if (idle && bus.i_we)   ibuf_q[bus.i_wr_addr] <= bus.i_wr_data;
      if (idle && bus.i_w_we) w_q[bus.i_w_row]      <= bus.i_w_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (acc_clr) begin
         acc_q <= '0;
      end else if (acc_en) begin
         for (int c = 0; c < xbar_size; c++)
            if (row_w[c]) acc_q[c] <= acc_q[c] + ACC_W'(row_in);
      end
   end

   for (genvar c = 0; c < xbar_size; c++) begin : g_sat
      assign sat_d[c] = output_datatype_size'(sat_u(32'(acc_q[c]), output_datatype_size));
   end

   cim_obuf #(
      .depth (xbar_size),
      .width (output_datatype_size)
   ) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .we    (commit),
      .wdata (sat_d),
      .raddr (bus.i_rd_addr),
      .rdata (bus.o_rd_data)
   );

endmodule

// File: tb/tb_cim_tile.sv
// Scoreboard bench for cim_tile at xbar_size=4: a behavioural crossbar model pushes
// expected column results at start, reads of the output buffer pop and compare.
module tb_cim_tile;

   localparam int XS = 4;
   localparam int DS = 2;
   localparam int OS = 2;

   logic clk;
   logic rst;

   cim_tile_if #(.xbar_size(XS), .datatype_size(DS), .output_datatype_size(OS)) bus ();

   cim_tile #(.xbar_size(XS), .datatype_size(DS), .output_datatype_size(OS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DS-1:0] ibuf_m [XS];
   logic [XS-1:0] w_m    [XS];
   int            sb     [$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_push();
      for (int c = 0; c < XS; c++) begin
         int s = 0;
         for (int r = 0; r < XS; r++)
            if (w_m[r][c]) s += int'(ibuf_m[r]);
         sb.push_back(s > 3 ? 3 : s);
      end
   endfunction

   task automatic write_ibuf(input int a, input int d);
      bus.i_we = 1'b1; bus.i_wr_addr = 2'(a); bus.i_wr_data = 2'(d);
      ibuf_m[a] = 2'(d);
      tick();
      bus.i_we = 1'b0;
   endtask

   task automatic write_w(input int r, input logic [XS-1:0] d);
      bus.i_w_we = 1'b1; bus.i_w_row = 2'(r); bus.i_w_data = d;
      w_m[r] = d;
      tick();
      bus.i_w_we = 1'b0;
   endtask

   task automatic read_col(input int a, output int d);
      bus.i_rd_addr = 2'(a);
      tick();
      d = int'(bus.o_rd_data);
   endtask

   // Starts a run, returns the number of busy cycles seen and whether done followed.
   task automatic run_mvm(output int nbusy, output logic done_seen);
      model_push();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0; bus.i_we = 1'b0; bus.i_w_we = 1'b0;
      nbusy = 0;
      while (bus.o_busy && nbusy < 20) begin
         nbusy++;
         tick();
      end
      done_seen = bus.o_done;
   endtask

   task automatic test_reset();
      int d, e;
      rst = 1'b0;
      #12;
      n_checks++;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_rd_data !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs busy=%0b done=%0b rd=%0d exp 0/0/0", bus.o_busy, bus.o_done, bus.o_rd_data);
      end
      tick();
      rst = 1'b1;
      tick();
      for (int c = 0; c < XS; c++) sb.push_back(0);
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL reset_obuf col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_saturate();
      int nb, d, e; logic dn;
      write_ibuf(0, 1); write_ibuf(1, 2); write_ibuf(2, 3); write_ibuf(3, 0);
      for (int r = 0; r < XS; r++) write_w(r, 4'b0001);
      run_mvm(nb, dn);
      n_checks++;
      if (nb !== 5) begin n_fail++; $display("FAIL sat_busy_len got %0d exp 5", nb); end
      n_checks++;
      if (dn !== 1'b1) begin n_fail++; $display("FAIL sat_done got %0b exp 1", dn); end
      tick();
      n_checks++;
      if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL sat_done_pulse got %0b exp 0", bus.o_done); end
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL sat_obuf col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_pattern();
      int nb, d, e; logic dn;
      write_ibuf(0, 1); write_ibuf(1, 0); write_ibuf(2, 0); write_ibuf(3, 0);
      write_w(0, 4'b1010); write_w(1, 4'b0000); write_w(2, 4'b0000); write_w(3, 4'b0000);
      run_mvm(nb, dn);
      n_checks++;
      if (nb !== 5 || dn !== 1'b1) begin n_fail++; $display("FAIL pat_handshake busy=%0d done=%0b exp 5/1", nb, dn); end
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL pat_obuf col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_busy_ignore();
      int nb, nd, d, e; logic dn;
      write_ibuf(0, 2); write_ibuf(1, 0); write_ibuf(2, 0); write_ibuf(3, 0);
      write_w(0, 4'b0001); write_w(1, 4'b0000); write_w(2, 4'b0000); write_w(3, 4'b0000);
      model_push();
      bus.i_start = 1'b1;
      tick();
      nb = 0; nd = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.o_busy) begin
            nb++;
            bus.i_start = 1'b1;
            bus.i_we = 1'b1; bus.i_wr_addr = 2'd0; bus.i_wr_data = 2'd1;
            bus.i_w_we = 1'b1; bus.i_w_row = 2'd0; bus.i_w_data = 4'b1111;
         end else begin
            bus.i_start = 1'b0; bus.i_we = 1'b0; bus.i_w_we = 1'b0;
         end
         if (bus.o_done) nd++;
         tick();
      end
      bus.i_start = 1'b0; bus.i_we = 1'b0; bus.i_w_we = 1'b0;
      n_checks++;
      if (nb !== 5) begin n_fail++; $display("FAIL ign_busy_len got %0d exp 5", nb); end
      n_checks++;
      if (nd !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d exp 1", nd); end
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL ign_obuf col%0d got %0d exp %0d", c, d, e); end
      end
      run_mvm(nb, dn);
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL ign_frozen col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_reset_mid();
      int nb, nd, d, e; logic dn;
      for (int r = 0; r < XS; r++) begin write_ibuf(r, 1); write_w(r, 4'b1111); end
      run_mvm(nb, dn);
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rmid_pre col%0d got %0d exp %0d", c, d, e); end
      end
      read_col(0, d);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_rd_data !== 2'd0) begin
         n_fail++;
         $display("FAIL rmid_async busy=%0b done=%0b rd=%0d exp 0/0/0", bus.o_busy, bus.o_done, bus.o_rd_data);
      end
      tick(); tick();
      rst = 1'b1;
      nd = 0; nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.o_done) nd++;
         if (bus.o_busy) nb++;
         tick();
      end
      n_checks++;
      if (nd !== 0 || nb !== 0) begin n_fail++; $display("FAIL rmid_no_run done=%0d busy=%0d exp 0/0", nd, nb); end
      for (int c = 0; c < XS; c++) sb.push_back(0);
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rmid_obuf col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_write_with_start();
      int nb, d, e; logic dn;
      write_w(0, 4'b1111); write_w(1, 4'b0000); write_w(2, 4'b0000); write_w(3, 4'b0000);
      write_ibuf(0, 0);
      bus.i_we = 1'b1; bus.i_wr_addr = 2'd0; bus.i_wr_data = 2'd3;
      ibuf_m[0] = 2'd3;
      run_mvm(nb, dn);
      n_checks++;
      if (nb !== 5 || dn !== 1'b1) begin n_fail++; $display("FAIL wst_handshake busy=%0d done=%0b exp 5/1", nb, dn); end
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL wst_obuf col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_read_across_commit();
      int nb, n, d, e, old_v; logic dn;
      write_ibuf(0, 1); write_ibuf(1, 0); write_ibuf(2, 0); write_ibuf(3, 0);
      write_w(0, 4'b0001); write_w(1, 4'b0000); write_w(2, 4'b0000); write_w(3, 4'b0000);
      run_mvm(nb, dn);
      for (int c = 0; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rac_first col%0d got %0d exp %0d", c, d, e); end
      end
      old_v = 1;
      write_ibuf(0, 2);
      model_push();
      bus.i_rd_addr = 2'd0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      n = 0;
      while (!bus.o_done && n < 20) begin
         n_checks++;
         if (int'(bus.o_rd_data) !== old_v) begin
            n_fail++; $display("FAIL rac_during cyc%0d got %0d exp %0d", n, bus.o_rd_data, old_v);
         end
         n++;
         tick();
      end
      n_checks++;
      if (bus.o_done !== 1'b1) begin n_fail++; $display("FAIL rac_done_timeout got %0b exp 1", bus.o_done); end
      n_checks++;
      if (int'(bus.o_rd_data) !== old_v) begin n_fail++; $display("FAIL rac_commit_edge got %0d exp %0d", bus.o_rd_data, old_v); end
      tick();
      e = sb.pop_front(); n_checks++;
      if (int'(bus.o_rd_data) !== e) begin n_fail++; $display("FAIL rac_after got %0d exp %0d", bus.o_rd_data, e); end
      for (int c = 1; c < XS; c++) begin
         read_col(c, d); e = sb.pop_front(); n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rac_rest col%0d got %0d exp %0d", c, d, e); end
      end
   endtask

   task automatic test_random();
      int nb, d, e; logic dn;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < XS; r++) begin
            write_ibuf(r, int'($urandom_range(0, 3)));
            write_w(r, 4'($urandom_range(0, 15)));
         end
         run_mvm(nb, dn);
         n_checks++;
         if (nb !== 5 || dn !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_handshake busy=%0d done=%0b exp 5/1", k, nb, dn); end
         for (int c = 0; c < XS; c++) begin
            read_col(c, d); e = sb.pop_front(); n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL rnd%0d_obuf col%0d got %0d exp %0d", k, c, d, e); end
         end
      end
   endtask

   initial begin
      bus.i_we = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      bus.i_start = 1'b0;
      bus.i_w_we = 1'b0; bus.i_w_row = '0; bus.i_w_data = '0;
      bus.i_rd_addr = '0;
      test_reset();
      test_saturate();
      test_pattern();
      test_busy_ignore();
      test_reset_mid();
      test_write_with_start();
      test_read_across_commit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
